aes_key_expander: RTL and testbench



---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_key_expander_if.sv | 24 ++
 rtl/aes_sub_word.sv | 11 +
 rtl/aes_key_expander.sv | 134 +++++++++++++
 tb/tb_aes_key_expander.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: S-box, key-schedule constants, FSM encoding and
// the InvMixColumns helper used on the round-key read path.
package aes_pkg;

  localparam int unsigned AES_WORD_W = 32;

  localparam logic [7:0] AES_RCON_INIT  = 8'h01;
  localparam logic [7:0] AES_XTIME_POLY = 8'h1b;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8); also advances the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_XTIME_POLY : 8'h00);
  endfunction

  // InvMixColumns on one column, byte 0 in the MSBs.
  function automatic logic [AES_WORD_W-1:0] inv_mix_column(input logic [AES_WORD_W-1:0] col);
    logic [7:0] a [4];
    logic [7:0] x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a[k]  = col[AES_WORD_W-1-8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key load handshake, status and round-key read port of the key expander.
interface aes_key_expander_if
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4
);
  logic [Nk*AES_WORD_W-1:0] key_in;
  logic                     key_valid;
  logic                     key_ready;
  logic                     busy;
  logic                     keys_valid;
  logic [3:0]               rd_round;
  logic [127:0]             round_key;

  modport master (
    output key_in, key_valid, rd_round,
    input  key_ready, busy, keys_valid, round_key
  );

  modport slave (
    input  key_in, key_valid, rd_round,
    output key_ready, busy, keys_valid, round_key
  );
endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [AES_WORD_W-1:0] word_i,
  output logic [AES_WORD_W-1:0] word_o_c
);
  for (genvar k = 0; k < 4; k++) begin : g_byte
    assign word_o_c[8*k +: 8] = AES_SBOX[word_i[8*k +: 8]];
  end
endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule, one word per clock, full schedule held in a
// register file with a combinational round-key read port.
// Build option: AES_KEYEXP_EQINV_EN applies InvMixColumns to the middle
// round keys on the read path (Equivalent Inverse Cipher keys).
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4
) (
  input logic              clk,
  input logic              rst,
  aes_key_expander_if.slave bus
);
  localparam int unsigned NR    = Nk + 6;
  localparam int unsigned NW    = 4 * (NR + 1);
  localparam int unsigned CNT_W = 6;
  localparam int unsigned MOD_W = 3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      i_q, i_d;
  logic [MOD_W-1:0]      mod_q, mod_d;
  logic [7:0]            rcon_q, rcon_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  kv_q, kv_d;
  logic                  load_c, wr_en_c;
  logic [AES_WORD_W-1:0] w_q [NW];
  logic [AES_WORD_W-1:0] prev_c, back_c, sub_in_c, sub_out_c, temp_c, new_word_c;
  logic [CNT_W-1:0]      rd_base_c;
  logic [127:0]          round_key_c;

  // State, counters and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      mod_q   <= '0;
      rcon_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      mod_q   <= mod_d;
      rcon_q  <= rcon_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      kv_q    <= kv_d;
    end
  end

  // Next state: load from IDLE/DONE, one word per cycle in EXPAND.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    mod_d   = mod_q;
    rcon_d  = rcon_q;
    load_c  = 1'b0;
    wr_en_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.key_valid) begin
          state_d = ST_EXPAND;
          i_d     = CNT_W'(Nk);
          mod_d   = '0;
          rcon_d  = AES_RCON_INIT;
          load_c  = 1'b1;
        end
      end
      ST_EXPAND: begin
        wr_en_c = 1'b1;
        i_d     = i_q + CNT_W'(1);
        mod_d   = (mod_q == MOD_W'(Nk - 1)) ? '0 : mod_q + MOD_W'(1);
        if (mod_q == '0) rcon_d = xtime(rcon_q);
        if (i_q == CNT_W'(NW - 1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d != ST_EXPAND);
    busy_d  = (state_d == ST_EXPAND);
    kv_d    = (state_d == ST_DONE);
  end

  // Recurrence w[i] = w[i-Nk] ^ f(w[i-1]); one shared SubWord unit.
  always_comb begin
    prev_c   = w_q[i_q - CNT_W'(1)];
    back_c   = w_q[i_q - CNT_W'(Nk)];
    sub_in_c = (mod_q == '0) ? {prev_c[23:0], prev_c[31:24]} : prev_c;
    temp_c   = prev_c;
    if (mod_q == '0)
      temp_c = sub_out_c ^ {rcon_q, 24'h0};
    else if (Nk > 6 && mod_q == MOD_W'(4))
      temp_c = sub_out_c;
    new_word_c = back_c ^ temp_c;
  end

  aes_sub_word u_sub_word (
    .word_i   (sub_in_c),
    .word_o_c (sub_out_c)
  );

  // Schedule storage; intentionally not reset.
  always_ff @(posedge clk) begin
    if (load_c) begin
      for (int k = 0; k < int'(Nk); k++)
        w_q[k] <= bus.key_in[AES_WORD_W*(int'(Nk)-1-k) +: AES_WORD_W];
    end else if (wr_en_c) begin
      w_q[i_q] <= new_word_c;
    end
  end

  assign rd_base_c = {bus.rd_round, 2'b00};

  // Combinational round-key read; out-of-range rounds read as zero.
  always_comb begin
    round_key_c = '0;
    if (bus.rd_round <= 4'(NR)) begin
      for (int k = 0; k < 4; k++) begin
`ifdef AES_KEYEXP_EQINV_EN
        if (bus.rd_round != 4'd0 && bus.rd_round != 4'(NR))
          round_key_c[127-32*k -: 32] = inv_mix_column(w_q[rd_base_c + CNT_W'(k)]);
        else
`endif
          round_key_c[127-32*k -: 32] = w_q[rd_base_c + CNT_W'(k)];
      end
    end
  end

  assign bus.key_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.keys_valid = kv_q;
  assign bus.round_key  = round_key_c;
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander with Nk = 4, 6 and 8 instances and a
// behavioural key-schedule / inverse-cipher model.
module tb_aes_key_expander;
  localparam int NI = 3;

  localparam logic [127:0] K128    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192    = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R10_128 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] R12_192 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [127:0] R14_256 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] CT      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_KEYEXP_EQINV_EN
  localparam bit EQ = 1'b1;
`else
  localparam bit EQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [255:0] key_all [NI];
  logic         kvalid  [NI];
  logic [3:0]   rd      [NI];
  logic         ready_a [NI];
  logic         busy_a  [NI];
  logic         kv_a    [NI];
  logic [127:0] rk_a    [NI];

  int           m_cnt [NI];
  logic         m_kv  [NI];
  logic [255:0] m_key [NI];

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned NKG = 4 + 2 * g;
    aes_key_expander_if #(.Nk(NKG)) bus ();
    assign bus.key_in    = key_all[g][255 -: NKG*32];
    assign bus.key_valid = kvalid[g];
    assign bus.rd_round  = rd[g];
    assign ready_a[g]    = bus.key_ready;
    assign busy_a[g]     = bus.busy;
    assign kv_a[g]       = bus.keys_valid;
    assign rk_a[g]       = bus.round_key;
    aes_key_expander #(.Nk(NKG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // ---------------- GF(2^8) and AES reference functions ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [31:0] imc(input logic [31:0] c);
    logic [7:0] a0 = c[31:24];
    logic [7:0] a1 = c[23:16];
    logic [7:0] a2 = c[15:8];
    logic [7:0] a3 = c[7:0];
    return {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
            gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
            gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
            gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
  endfunction

  // FIPS-197 KeyExpansion written directly from the recurrence.
  function automatic void expand(input int nk, input logic [255:0] key, output logic [31:0] w [60]);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endfunction

  function automatic logic [127:0] raw_rk(input int nk, input logic [255:0] key, input int r);
    logic [31:0] w [60];
    if (r > nk + 6) return 128'h0;
    expand(nk, key, w);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] exp_rk(input int g, input int r);
    logic [127:0] v;
    int nr;
    nr = 4 + 2 * g + 6;
    v  = raw_rk(4 + 2 * g, m_key[g], r);
    if (EQ && r > 0 && r < nr)
      for (int k = 0; k < 4; k++) v[127-32*k -: 32] = imc(v[127-32*k -: 32]);
    return v;
  endfunction

  function automatic logic [127:0] isr(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] isb(input logic [127:0] s);
    logic [127:0] o;
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = isbox_t[s[127-8*j -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] imx(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = imc(s[127-32*c -: 32]);
    return o;
  endfunction

  // AES-128 inverse cipher; eq selects the equivalent-inverse ordering.
  function automatic logic [127:0] decrypt(input logic [127:0] ct, input logic [127:0] rk [11], input bit eq);
    logic [127:0] s;
    s = ct ^ rk[10];
    for (int r = 9; r >= 1; r--) begin
      if (!eq) s = imx(isb(isr(s)) ^ rk[r]);
      else     s = imx(isr(isb(s))) ^ rk[r];
    end
    return isb(isr(s)) ^ rk[0];
  endfunction

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Cycle-level model of handshake, busy and keys_valid.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < NI; g++) begin
        m_cnt[g] <= 0;
        m_kv[g]  <= 1'b0;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        if (m_cnt[g] == 0 && kvalid[g]) begin
          m_cnt[g] <= 4 * (4 + 2 * g + 7) - (4 + 2 * g);
          m_kv[g]  <= 1'b0;
          m_key[g] <= key_all[g];
        end else if (m_cnt[g] > 0) begin
          m_cnt[g] <= m_cnt[g] - 1;
          if (m_cnt[g] == 1) m_kv[g] <= 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int g, input logic [255:0] key);
    key_all[g] = key;
    kvalid[g]  = 1'b1;
    tick();
    kvalid[g]  = 1'b0;
  endtask

  task automatic wait_kv(input int g, input int lat, input string nm);
    int n = 0;
    while (kv_a[g] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(nm, 128'(n), 128'(lat));
  endtask

  task automatic rdk(input int g, input int r, output logic [127:0] v);
    rd[g] = 4'(r);
    #1;
    v = rk_a[g];
  endtask

  task automatic sweep(input int g);
    for (int r = 0; r < 16; r++) begin
      rd[g] = 4'(r);
      tick();
    end
  endtask

  initial begin
    logic [127:0] v;
    logic [127:0] rks [11];
    logic [7:0]   inv;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
    for (int g = 0; g < NI; g++) begin
      kvalid[g]  = 1'b0;
      key_all[g] = '0;
      rd[g]      = 4'd0;
    end

    fork
      begin : compare
        forever begin
          @(negedge clk);
          for (int g = 0; g < NI; g++) begin
            chk($sformatf("key_ready[%0d]", g), 128'(ready_a[g]), 128'(m_cnt[g] == 0));
            chk($sformatf("busy[%0d]", g), 128'(busy_a[g]), 128'(m_cnt[g] != 0));
            chk($sformatf("keys_valid[%0d]", g), 128'(kv_a[g]), 128'(m_kv[g]));
            if (m_kv[g])
              chk($sformatf("round_key[%0d] r=%0d", g, rd[g]), rk_a[g], exp_rk(g, int'(rd[g])));
          end
        end
      end
      begin : stimulus
        // Pin the reference model with known answers.
        chk("model_sbox_00", 128'(sbox_t[8'h00]), 128'h63);
        chk("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
        chk("model_imc", 128'(imc(32'h8e4da1bc)), 128'hdb135345);
        chk("model_r10_128", raw_rk(4, {K128, 128'h0}, 10), R10_128);
        chk("model_r14_256", raw_rk(8, K256, 14), R14_256);
        for (int r = 0; r < 11; r++) rks[r] = raw_rk(4, {K128, 128'h0}, r);
        chk("model_decrypt", decrypt(CT, rks, 1'b0), PT);

        repeat (3) tick();
        for (int g = 0; g < NI; g++) begin
          chk($sformatf("rst_ready[%0d]", g), 128'(ready_a[g]), 128'h1);
          chk($sformatf("rst_busy[%0d]", g), 128'(busy_a[g]), 128'h0);
          chk($sformatf("rst_kv[%0d]", g), 128'(kv_a[g]), 128'h0);
        end
        rst = 1'b0;
        tick();

        // AES-128 / 192 / 256 schedules.
        load(0, {K128, 128'h0});
        chk("busy_after_accept", 128'(busy_a[0]), 128'h1);
        wait_kv(0, 40, "latency_128");
        rdk(0, 0, v);  chk("r0_128", v, K128);
        rdk(0, 10, v); chk("r10_128", v, R10_128);
        rdk(0, 11, v); chk("r11_128_zero", v, 128'h0);
        sweep(0);

        load(1, {K192, 64'h0});
        wait_kv(1, 46, "latency_192");
        rdk(1, 0, v);  chk("r0_192", v, K192[191:64]);
        rdk(1, 12, v); chk("r12_192", v, R12_192);
        sweep(1);

        load(2, K256);
        wait_kv(2, 52, "latency_256");
        rdk(2, 14, v); chk("r14_256", v, R14_256);
        rdk(2, 15, v); chk("r15_256_zero", v, 128'h0);
        sweep(2);

        // Reload from DONE, then key_valid held high through EXPAND.
        key_all[0] = {K128, 128'h0};
        kvalid[0]  = 1'b1;
        tick();
        chk("reload_kv_drop", 128'(kv_a[0]), 128'h0);
        key_all[0] = {128'hffeeddccbbaa99887766554433221100, 128'h0};
        repeat (30) tick();
        chk("bp_ready_low", 128'(ready_a[0]), 128'h0);
        kvalid[0] = 1'b0;
        wait_kv(0, 10, "latency_reload_tail");
        rdk(0, 10, v); chk("reload_r10", v, R10_128);
        rdk(0, 0, v);  chk("reload_r0", v, K128);
        sweep(0);

        // Asynchronous reset mid-expansion.
        load(0, {128'hffffffffffffffffffffffffffffffff, 128'h0});
        repeat (19) tick();
        rst = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
          chk($sformatf("arst_ready[%0d]", g), 128'(ready_a[g]), 128'h1);
          chk($sformatf("arst_busy[%0d]", g), 128'(busy_a[g]), 128'h0);
          chk($sformatf("arst_kv[%0d]", g), 128'(kv_a[g]), 128'h0);
        end
        tick();
        rst = 1'b0;
        tick();
        load(0, {K128, 128'h0});
        wait_kv(0, 40, "latency_after_reset");
        rdk(0, 10, v); chk("post_reset_r10", v, R10_128);

        // End-to-end decryption with the keys read from the port.
        for (int r = 0; r < 11; r++) rdk(0, r, rks[r]);
        chk("decrypt_plaintext", decrypt(CT, rks, EQ), PT);
`ifdef AES_KEYEXP_EQINV_EN
        chk("eqinv_r0", rks[0], K128);
        chk("eqinv_r10", rks[10], R10_128);
        chk("eqinv_r5", rks[5], imx(raw_rk(4, {K128, 128'h0}, 5)));
`endif
        sweep(0);
        tick();
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
